cpu7b_mem_arb: RTL and testbench

- Two-master, single-outstanding arbiter that shares one SRAM-like memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the core's IFU/LSU request interfaces and the external bus bridge.
- Registers the winning request, drives it downstream, and routes the response back to its owner.
- LSU has fixed priority; a starvation counter guarantees the IFU forward progress.

---
 rtl/cpu7b_mem_arb.sv | 170 +++++++++++++++++
 tb/tb_cpu7b_mem_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7b_mem_arb.sv
// cpu7b_mem_arb
//   Shares one SRAM-like memory port between the instruction fetch unit
//   (read-only) and the load/store unit (read/write). A single transaction
//   is outstanding at a time. The winning request is registered and driven
//   downstream, and the response is routed back to the master that owns it.
//   The LSU has fixed priority. A starvation counter lets the IFU win once
//   after STARVE_LIMIT consecutive contended LSU grants.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   ifu_req/ifu_addr      : IFU read request, held until ifu_addr_ok
//   ifu_addr_ok           : IFU request accepted (1-cycle pulse)
//   ifu_data_ok/ifu_rdata : IFU read data valid / data
//   lsu_req/wr/wstrb/addr/wdata : LSU request, held until lsu_addr_ok
//   lsu_addr_ok           : LSU request accepted (1-cycle pulse)
//   lsu_data_ok/lsu_rdata : LSU read data valid or write done / data
//   bus_req/wr/wstrb/addr/wdata : registered downstream request
//   bus_addr_ok           : downstream accepted the request
//   bus_data_ok/bus_rdata : downstream response
//   arb_busy              : a transaction is in flight
module cpu7b_mem_arb #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ifu_req,
   input  logic [ADDR_WIDTH-1:0]   ifu_addr,
   output logic                    ifu_addr_ok,
   output logic                    ifu_data_ok,
   output logic [DATA_WIDTH-1:0]   ifu_rdata,
   input  logic                    lsu_req,
   input  logic                    lsu_wr,
   input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata,
   output logic                    lsu_addr_ok,
   output logic                    lsu_data_ok,
   output logic [DATA_WIDTH-1:0]   lsu_rdata,
   output logic                    bus_req,
   output logic                    bus_wr,
   output logic [DATA_WIDTH/8-1:0] bus_wstrb,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]   bus_wdata,
   input  logic                    bus_addr_ok,
   input  logic                    bus_data_ok,
   input  logic [DATA_WIDTH-1:0]   bus_rdata,
   output logic                    arb_busy
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } state_t;

   state_t                state_q,      state_d;
   logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
   logic                  owner_ifu_q,  owner_ifu_d;
   logic                  bus_wr_q,     bus_wr_d;
   logic [STRB_W-1:0]     bus_wstrb_q,  bus_wstrb_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q,   bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q,  bus_wdata_d;
   logic                  lsu_wins;

   // The IFU overrides LSU priority only when it is actually waiting and
   // has already lost STARVE_LIMIT contended grants in a row.
   assign lsu_wins = lsu_req && !(ifu_req && (starve_cnt_q == CNT_MAX));

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      owner_ifu_d  = owner_ifu_q;
      bus_wr_d     = bus_wr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      ifu_addr_ok  = 1'b0;
      lsu_addr_ok  = 1'b0;
      ifu_data_ok  = 1'b0;
      lsu_data_ok  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lsu_wins) begin
               lsu_addr_ok = 1'b1;
               owner_ifu_d = 1'b0;
               bus_wr_d    = lsu_wr;
               bus_wstrb_d = lsu_wstrb;
               bus_addr_d  = lsu_addr;
               bus_wdata_d = lsu_wdata;
               state_d     = ST_ADDR;
               if (!ifu_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q != CNT_MAX) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
            end else if (ifu_req) begin
               // Fetches are always reads; write fields are cleared so a
               // stale LSU strobe can never reach the bus.
               ifu_addr_ok  = 1'b1;
               owner_ifu_d  = 1'b1;
               bus_wr_d     = 1'b0;
               bus_wstrb_d  = '0;
               bus_addr_d   = ifu_addr;
               bus_wdata_d  = '0;
               starve_cnt_d = '0;
               state_d      = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus_addr_ok) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bus_data_ok) begin
               ifu_data_ok = owner_ifu_q;
               lsu_data_ok = !owner_ifu_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A grant or response seen during reset is discarded, so the
      // requesters must not see a handshake pulse either.
      if (reset) begin
         ifu_addr_ok = 1'b0;
         lsu_addr_ok = 1'b0;
         ifu_data_ok = 1'b0;
         lsu_data_ok = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= '0;
         owner_ifu_q  <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_wstrb_q  <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         owner_ifu_q  <= owner_ifu_d;
         bus_wr_q     <= bus_wr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
      end
   end

   assign bus_req   = (state_q == ST_ADDR);
   assign arb_busy  = (state_q != ST_IDLE);
   assign bus_wr    = bus_wr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign ifu_rdata = bus_rdata;
   assign lsu_rdata = bus_rdata;

endmodule

// File: tb/tb_cpu7b_mem_arb.sv
// Testbench for cpu7b_mem_arb: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_cpu7b_mem_arb;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          ifu_req;
   logic [AW-1:0] ifu_addr;
   logic          ifu_addr_ok, ifu_data_ok;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req, lsu_wr;
   logic [SW-1:0] lsu_wstrb;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata;
   logic          lsu_addr_ok, lsu_data_ok;
   logic [DW-1:0] lsu_rdata;
   logic          bus_req, bus_wr;
   logic [SW-1:0] bus_wstrb;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_addr_ok, bus_data_ok;
   logic [DW-1:0] bus_rdata;
   logic          arb_busy;

   int checks = 0;
   int errors = 0;

   cpu7b_mem_arb #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ifu_req    (ifu_req),
      .ifu_addr   (ifu_addr),
      .ifu_addr_ok(ifu_addr_ok),
      .ifu_data_ok(ifu_data_ok),
      .ifu_rdata  (ifu_rdata),
      .lsu_req    (lsu_req),
      .lsu_wr     (lsu_wr),
      .lsu_wstrb  (lsu_wstrb),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_addr_ok(lsu_addr_ok),
      .lsu_data_ok(lsu_data_ok),
      .lsu_rdata  (lsu_rdata),
      .bus_req    (bus_req),
      .bus_wr     (bus_wr),
      .bus_wstrb  (bus_wstrb),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok),
      .bus_rdata  (bus_rdata),
      .arb_busy   (arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Transaction-level model: one optional in-flight transaction with an
   // "address accepted" flag, plus an integer count of contended LSU wins.
   // ------------------------------------------------------------------
   logic          m_valid = 1'b0;
   logic          m_busy, m_sent, m_own_ifu, m_wr;
   logic [SW-1:0] m_wstrb;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            m_starve;

   logic          n_busy, n_sent, n_own_ifu, n_wr;
   logic [SW-1:0] n_wstrb;
   logic [AW-1:0] n_addr;
   logic [DW-1:0] n_wdata;
   int            n_starve;

   always @(negedge clk) begin : cmp
      logic lwin, iwin, dok;
      lwin = !m_busy && lsu_req && !(ifu_req && m_starve == LIM);
      iwin = !m_busy && ifu_req && !lwin;
      dok  = m_busy && m_sent && bus_data_ok && !reset;
      if (m_valid) begin
         chk("ctrl {iaok,laok,idok,ldok,breq,busy}",
             64'({ifu_addr_ok, lsu_addr_ok, ifu_data_ok, lsu_data_ok, bus_req, arb_busy}),
             64'({iwin && !reset, lwin && !reset, dok && m_own_ifu, dok && !m_own_ifu,
                  m_busy && !m_sent, m_busy}));
         chk("bus_addr", 64'(bus_addr), 64'(m_addr));
         chk("bus_wr_wstrb", 64'({bus_wr, bus_wstrb}), 64'({m_wr, m_wstrb}));
         if (m_wr) chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
         chk("ifu_rdata", 64'(ifu_rdata), 64'(bus_rdata));
         chk("lsu_rdata", 64'(lsu_rdata), 64'(bus_rdata));
      end
      n_busy    <= m_busy;
      n_sent    <= m_sent;
      n_own_ifu <= m_own_ifu;
      n_wr      <= m_wr;
      n_wstrb   <= m_wstrb;
      n_addr    <= m_addr;
      n_wdata   <= m_wdata;
      n_starve  <= m_starve;
      if (reset) begin
         n_busy <= 1'b0; n_sent <= 1'b0; n_own_ifu <= 1'b0; n_wr <= 1'b0;
         n_wstrb <= '0; n_addr <= '0; n_wdata <= '0; n_starve <= 0;
      end else if (lwin) begin
         n_busy <= 1'b1; n_sent <= 1'b0; n_own_ifu <= 1'b0; n_wr <= lsu_wr;
         n_wstrb <= lsu_wstrb; n_addr <= lsu_addr; n_wdata <= lsu_wdata;
         n_starve <= ifu_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      end else if (iwin) begin
         n_busy <= 1'b1; n_sent <= 1'b0; n_own_ifu <= 1'b1; n_wr <= 1'b0;
         n_wstrb <= '0; n_addr <= ifu_addr; n_wdata <= '0; n_starve <= 0;
      end else if (m_busy && !m_sent && bus_addr_ok) begin
         n_sent <= 1'b1;
      end else if (m_busy && m_sent && bus_data_ok) begin
         n_busy <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (reset) m_valid <= 1'b1;
      m_busy    <= n_busy;
      m_sent    <= n_sent;
      m_own_ifu <= n_own_ifu;
      m_wr      <= n_wr;
      m_wstrb   <= n_wstrb;
      m_addr    <= n_addr;
      m_wdata   <= n_wdata;
      m_starve  <= n_starve;
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // One fully contended grant: both masters request, the bus accepts the
   // address one cycle later and responds the cycle after that.
   task automatic contended_grant(output byte who);
      ifu_req = 1'b1;
      lsu_req = 1'b1;
      lsu_wr  = 1'b0;
      settle();
      who = lsu_addr_ok ? "L" : (ifu_addr_ok ? "I" : "-");
      tick();
      bus_addr_ok = 1'b1;
      settle();
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1;
      settle();
      tick();
      bus_data_ok = 1'b0;
   endtask

   initial begin : drive
      byte   who;
      string exp_order;
      int    pulses;
      logic  prev_iack, prev_lack;

      reset = 1'b1;
      ifu_req = 1'b0; ifu_addr = '0;
      lsu_req = 1'b0; lsu_wr = 1'b0; lsu_wstrb = '0; lsu_addr = '0; lsu_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      settle();
      chk("rst bus_req", 64'(bus_req), 64'(0));
      chk("rst arb_busy", 64'(arb_busy), 64'(0));
      chk("rst bus_addr", 64'(bus_addr), 64'(0));
      chk("rst bus_wdata", 64'(bus_wdata), 64'(0));
      chk("rst bus_wr_wstrb", 64'({bus_wr, bus_wstrb}), 64'(0));

      // Stray data_ok while idle
      tick();
      bus_data_ok = 1'b1;
      settle();
      chk("stray idle data_ok", 64'({ifu_data_ok, lsu_data_ok, arb_busy}), 64'(0));

      // IFU-only read
      tick();
      bus_data_ok = 1'b0;
      ifu_req = 1'b1; ifu_addr = 32'h1c00_0000;
      settle();
      chk("ifu c0 addr_ok {i,l}", 64'({ifu_addr_ok, lsu_addr_ok}), 64'(2'b10));
      tick();
      ifu_req = 1'b0; bus_addr_ok = 1'b1;
      settle();
      chk("ifu c1 bus_req", 64'(bus_req), 64'(1));
      chk("ifu c1 bus_addr", 64'(bus_addr), 64'h1c00_0000);
      chk("ifu c1 bus_wr", 64'(bus_wr), 64'(0));
      chk("ifu c1 arb_busy", 64'(arb_busy), 64'(1));
      tick();
      bus_addr_ok = 1'b0;
      settle();
      chk("ifu c2 {busy,req,dok}", 64'({arb_busy, bus_req, ifu_data_ok}), 64'(3'b100));
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'h0280_0405;
      settle();
      chk("ifu c3 {idok,ldok,busy}", 64'({ifu_data_ok, lsu_data_ok, arb_busy}), 64'(3'b101));
      chk("ifu c3 ifu_rdata", 64'(ifu_rdata), 64'h0280_0405);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("ifu c4 arb_busy", 64'(arb_busy), 64'(0));

      // LSU write with a late address handshake and a stray data_ok in ADDR
      tick();
      lsu_req = 1'b1; lsu_wr = 1'b1; lsu_wstrb = 4'hF;
      lsu_addr = 32'h1c00_0100; lsu_wdata = 32'h5a;
      settle();
      chk("lsu wr addr_ok", 64'(lsu_addr_ok), 64'(1));
      tick();
      lsu_req = 1'b0; lsu_wr = 1'b0; lsu_wstrb = '0;
      lsu_addr = 32'hdead_beef; lsu_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         bus_data_ok = (i == 2);
         settle();
         chk($sformatf("lsu hold%0d bus_req", i), 64'(bus_req), 64'(1));
         chk($sformatf("lsu hold%0d bus_addr", i), 64'(bus_addr), 64'h1c00_0100);
         chk($sformatf("lsu hold%0d bus_wdata", i), 64'(bus_wdata), 64'h5a);
         chk($sformatf("lsu hold%0d wr_wstrb", i), 64'({bus_wr, bus_wstrb}), 64'h1f);
         chk($sformatf("lsu hold%0d data_ok", i), 64'({ifu_data_ok, lsu_data_ok}), 64'(0));
         tick();
      end
      bus_data_ok = 1'b0;
      bus_addr_ok = 1'b1;
      settle();
      tick();
      bus_addr_ok = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         bus_data_ok = (i == 1);
         settle();
         pulses += int'(lsu_data_ok);
         tick();
      end
      bus_data_ok = 1'b0;
      chk("lsu wr data_ok pulses", 64'(pulses), 64'(1));

      // Contention priority and starvation guard, from a cleared counter
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_order = "LLLLILLLLI";
      for (int g = 0; g < 10; g++) begin
         contended_grant(who);
         chk($sformatf("grant order %0d", g), 64'(who), 64'(exp_order[g]));
      end

      // Build the counter to its limit, then reset while waiting in DATA.
      for (int g = 0; g < 3; g++) begin
         contended_grant(who);
         chk($sformatf("pre-reset grant %0d", g), 64'(who), 64'("L"));
      end
      settle();
      chk("pre-reset 4th grant lsu", 64'(lsu_addr_ok), 64'(1));
      tick();
      bus_addr_ok = 1'b1;
      settle();
      tick();
      bus_addr_ok = 1'b0;
      reset = 1'b1;
      settle();
      chk("reset in DATA busy", 64'(arb_busy), 64'(1));
      tick();
      reset = 1'b0;
      bus_data_ok = 1'b1;
      settle();
      chk("after reset {busy,req}", 64'({arb_busy, bus_req}), 64'(0));
      chk("after reset data_ok", 64'({ifu_data_ok, lsu_data_ok}), 64'(0));
      chk("after reset addr_ok {i,l}", 64'({ifu_addr_ok, lsu_addr_ok}), 64'(2'b01));
      tick();
      ifu_req = 1'b0; lsu_req = 1'b0; bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
      settle();
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      settle();
      tick();
      bus_data_ok = 1'b0;

      // Randomized traffic
      prev_iack = 1'b0;
      prev_lack = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = ($urandom_range(0, 99) == 0);
         if (ifu_req && prev_iack) ifu_req = 1'b0;
         else if (ifu_req && $urandom_range(0, 19) == 0) ifu_req = 1'b0;
         else if (!ifu_req && $urandom_range(0, 2) == 0) begin
            ifu_req = 1'b1; ifu_addr = $urandom;
         end
         if (lsu_req && prev_lack) lsu_req = 1'b0;
         else if (lsu_req && $urandom_range(0, 19) == 0) lsu_req = 1'b0;
         else if (!lsu_req && $urandom_range(0, 1) == 0) begin
            lsu_req = 1'b1; lsu_wr = 1'($urandom_range(0, 1));
            lsu_wstrb = 4'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
         end
         bus_addr_ok = 1'($urandom_range(0, 1));
         bus_data_ok = ($urandom_range(0, 2) == 0);
         bus_rdata = $urandom;
         settle();
         prev_iack = ifu_addr_ok;
         prev_lack = lsu_addr_ok;
      end
      tick();
      reset = 1'b0;
      ifu_req = 1'b0; lsu_req = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
